sid_mixer_tdm: RTL and testbench

Parametrised, time-multiplexed SID voice mixer that generalises the fixed 3-voice mixing path to NUM_VOICES voices.
- One multiplier is shared across voices: one voice×envelope product per cycle.
- Routes each product to a filter or bypass accumulator, then presents the pre-filter sample to the external filter.
- Merges the filter LP/BP/HP returns with bypass, saturates, and applies the 4-bit master volume.
- Sits between the voice/envelope generators and the audio output; one frame runs per START (normally tied to CLKen).

---
 rtl/sid_mixer_tdm_if.sv | 34 +++
 rtl/sid_mixer_tdm.sv | 176 +++++++++++++++++
 tb/tb_sid_mixer_tdm.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sid_mixer_tdm_if.sv
// Signal bundle between the SID voice/envelope/filter blocks and the
// time-multiplexed mixer.
interface sid_mixer_tdm_if #(
  parameter int NUM_VOICES = 3,
  parameter int VOICE_W    = 12,
  parameter int ENV_W      = 8,
  parameter int OUT_W      = 16
);
  logic                          START;
  logic [NUM_VOICES*VOICE_W-1:0] VOICES;
  logic [NUM_VOICES*ENV_W-1:0]   ENVS;
  logic [NUM_VOICES-1:0]         FILT;
  logic [2:0]                    MODE;
  logic [3:0]                    VOLUME;
  logic signed [OUT_W-1:0]       FILT_LP;
  logic signed [OUT_W-1:0]       FILT_BP;
  logic signed [OUT_W-1:0]       FILT_HP;
  logic signed [OUT_W-1:0]       PRE_FILTER;
  logic                          PRE_VALID;
  logic signed [OUT_W-1:0]       OUTPUT;
  logic                          OUT_VALID;
  logic                          BUSY;
  logic                          CLIP;

  modport master (
    output START, VOICES, ENVS, FILT, MODE, VOLUME, FILT_LP, FILT_BP, FILT_HP,
    input  PRE_FILTER, PRE_VALID, OUTPUT, OUT_VALID, BUSY, CLIP
  );

  modport slave (
    input  START, VOICES, ENVS, FILT, MODE, VOLUME, FILT_LP, FILT_BP, FILT_HP,
    output PRE_FILTER, PRE_VALID, OUTPUT, OUT_VALID, BUSY, CLIP
  );
endinterface

// File: rtl/sid_mixer_tdm.sv
// Time-multiplexed SID voice mixer: one shared voice x envelope multiply per
// cycle, filter/bypass accumulation, filter-return merge, saturation, volume.
module sid_mixer_tdm #(
  parameter int NUM_VOICES = 3,
  parameter int VOICE_W    = 12,
  parameter int ENV_W      = 8,
  parameter int OUT_W      = 16,
  parameter int HEADROOM   = 3,
  parameter int FILTER_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  sid_mixer_tdm_if.slave bus
);
  localparam int PROD_W = VOICE_W + ENV_W + 1;
  localparam int SHIFT  = VOICE_W + ENV_W - OUT_W + HEADROOM;
  localparam int ACC_W  = OUT_W + $clog2(NUM_VOICES) + 2;
  localparam int SUM_W  = ACC_W + 2;
  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int WC_W   = $clog2(FILTER_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WAIT, S_VOL} state_t;

  function automatic logic signed [ACC_W-1:0] scale_q(input logic [VOICE_W-1:0] v,
                                                     input logic [ENV_W-1:0] e);
    logic signed [VOICE_W-1:0] s;
    logic signed [ENV_W:0]     es;
    logic signed [PROD_W-1:0]  p;
    logic signed [PROD_W-1:0]  sh;
    s  = {~v[VOICE_W-1], v[VOICE_W-2:0]};
    es = {1'b0, e};
    p  = s * es;
    sh = p >>> SHIFT;
    return ACC_W'(sh);
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SUM_W-1:0] x);
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    hi = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    lo = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    if (x > hi)      return hi[OUT_W-1:0];
    else if (x < lo) return lo[OUT_W-1:0];
    else             return x[OUT_W-1:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] apply_vol(input logic signed [OUT_W-1:0] x,
                                                       input logic [3:0] vol);
    logic signed [OUT_W+4:0] p;
    p = x * $signed({1'b0, vol});
    return OUT_W'(p >>> 4);
  endfunction

  state_t                        r_state, w_next;
  logic [NUM_VOICES*VOICE_W-1:0] r_voices;
  logic [NUM_VOICES*ENV_W-1:0]   r_envs;
  logic [NUM_VOICES-1:0]         r_filt;
  logic [2:0]                    r_mode;
  logic [3:0]                    r_volume;
  logic [IDX_W-1:0]              r_idx;
  logic [WC_W-1:0]               r_wcnt;
  logic signed [ACC_W-1:0]       r_acc_filt, r_acc_byp;
  logic signed [OUT_W-1:0]       r_clipped;
  logic                          r_clip_flag;
  logic signed [OUT_W-1:0]       r_pre_filter, r_output;
  logic                          r_pre_valid, r_out_valid, r_clip;

  logic                    w_start, w_mac_en, w_last, w_wait, w_sum_ld, w_vol_ld, w_busy;
  logic signed [ACC_W-1:0] w_q, w_acc_filt_nxt, w_acc_byp_nxt;
  logic signed [SUM_W-1:0] w_sum;
  logic signed [OUT_W-1:0] w_clipped;
  logic                    w_clip_flag;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.START) w_next = S_MAC;
      S_MAC:  if (r_idx == IDX_W'(NUM_VOICES - 1)) w_next = S_WAIT;
      S_WAIT: if (r_wcnt == WC_W'(FILTER_LAT - 1)) w_next = S_VOL;
      S_VOL:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_start  = (r_state == S_IDLE) && bus.START;
    w_mac_en = (r_state == S_MAC);
    w_last   = w_mac_en && (r_idx == IDX_W'(NUM_VOICES - 1));
    w_wait   = (r_state == S_WAIT);
    w_sum_ld = w_wait && (r_wcnt == WC_W'(FILTER_LAT - 1));
    w_vol_ld = (r_state == S_VOL);
    w_busy   = (r_state != S_IDLE);
  end

  // p0: shared multiply and routing of the current voice
  always_comb begin
    w_q            = scale_q(r_voices[r_idx*VOICE_W +: VOICE_W], r_envs[r_idx*ENV_W +: ENV_W]);
    w_acc_filt_nxt = r_acc_filt;
    w_acc_byp_nxt  = r_acc_byp;
    if (r_filt[r_idx]) w_acc_filt_nxt = r_acc_filt + w_q;
    else               w_acc_byp_nxt  = r_acc_byp + w_q;
  end

  // p1: merge enabled filter returns with the bypass path
  always_comb begin
    w_sum = SUM_W'(r_acc_byp);
    if (r_mode[0]) w_sum = w_sum + SUM_W'(bus.FILT_LP);
    if (r_mode[1]) w_sum = w_sum + SUM_W'(bus.FILT_BP);
    if (r_mode[2]) w_sum = w_sum + SUM_W'(bus.FILT_HP);
    w_clipped   = sat_out(w_sum);
    w_clip_flag = (w_sum != SUM_W'(w_clipped));
  end

  always_ff @(posedge CLK) begin
    if (w_start) begin
      r_voices <= bus.VOICES;
      r_envs   <= bus.ENVS;
      r_filt   <= bus.FILT;
      r_mode   <= bus.MODE;
      r_volume <= bus.VOLUME;
    end
    if (w_sum_ld) begin
      r_clipped   <= w_clipped;
      r_clip_flag <= w_clip_flag;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx        <= '0;
      r_wcnt       <= '0;
      r_acc_filt   <= '0;
      r_acc_byp    <= '0;
      r_pre_filter <= '0;
      r_pre_valid  <= 1'b0;
      r_output     <= '0;
      r_out_valid  <= 1'b0;
      r_clip       <= 1'b0;
    end else begin
      r_pre_valid <= w_last;
      r_out_valid <= w_vol_ld;
      if (w_start) begin
        r_idx      <= '0;
        r_acc_filt <= '0;
        r_acc_byp  <= '0;
      end else if (w_mac_en) begin
        if (!w_last) r_idx <= r_idx + 1'b1;
        r_acc_filt <= w_acc_filt_nxt;
        r_acc_byp  <= w_acc_byp_nxt;
      end
      if (w_last) begin
        r_pre_filter <= sat_out(SUM_W'(w_acc_filt_nxt));
        r_wcnt       <= '0;
      end else if (w_wait) begin
        r_wcnt <= r_wcnt + 1'b1;
      end
      // p2: volume scaling of the saturated mix
      if (w_vol_ld) begin
        r_output <= apply_vol(r_clipped, r_volume);
        r_clip   <= r_clip_flag;
      end
    end
  end

  assign bus.PRE_FILTER = r_pre_filter;
  assign bus.PRE_VALID  = r_pre_valid;
  assign bus.OUTPUT     = r_output;
  assign bus.OUT_VALID  = r_out_valid;
  assign bus.BUSY       = w_busy;
  assign bus.CLIP       = r_clip;
endmodule

// File: tb/tb_sid_mixer_tdm.sv
// Directed bench for sid_mixer_tdm: default 3-voice instance driven from a
// vector table, plus reset-abort, back-to-back and 8-voice sequences.
module tb_sid_mixer_tdm;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 CLK = ~CLK;

  sid_mixer_tdm_if #(.NUM_VOICES(3), .VOICE_W(12), .ENV_W(8), .OUT_W(16)) if0 ();
  sid_mixer_tdm_if #(.NUM_VOICES(8), .VOICE_W(12), .ENV_W(8), .OUT_W(16)) if8 ();

  sid_mixer_tdm #(.NUM_VOICES(3), .VOICE_W(12), .ENV_W(8), .OUT_W(16),
                  .HEADROOM(3), .FILTER_LAT(1)) dut (.CLK(CLK), .RST(RST), .bus(if0.slave));
  sid_mixer_tdm #(.NUM_VOICES(8), .VOICE_W(12), .ENV_W(8), .OUT_W(16),
                  .HEADROOM(2), .FILTER_LAT(1)) dut8 (.CLK(CLK), .RST(RST), .bus(if8.slave));

  typedef struct {
    logic [35:0] voices;
    logic [23:0] envs;
    logic [2:0]  filt;
    logic [2:0]  mode;
    logic [3:0]  vol;
    int          lp, bp, hp;
    int          pre, out;
    logic        clip;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_vec(input vec_t v);
    if0.VOICES  = v.voices;
    if0.ENVS    = v.envs;
    if0.FILT    = v.filt;
    if0.MODE    = v.mode;
    if0.VOLUME  = v.vol;
    if0.FILT_LP = 16'(v.lp);
    if0.FILT_BP = 16'(v.bp);
    if0.FILT_HP = 16'(v.hp);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    load_vec(v);
    check($sformatf("v%0d busy c0", k), if0.BUSY, 0);
    if0.START = 1'b1;
    step();
    if0.START  = 1'b0;
    if0.VOICES = 36'({$urandom(), $urandom()});
    if0.ENVS   = 24'($urandom());
    if0.FILT   = 3'($urandom());
    if0.MODE   = 3'($urandom());
    if0.VOLUME = 4'($urandom());
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("v%0d pre_valid c%0d", k, c), if0.PRE_VALID, (c == 4));
      check($sformatf("v%0d out_valid c%0d", k, c), if0.OUT_VALID, (c == 6));
      check($sformatf("v%0d busy c%0d", k, c), if0.BUSY, (c >= 1 && c <= 5));
      if (c == 4) check($sformatf("v%0d pre_filter", k), if0.PRE_FILTER, v.pre);
      if (c == 6) begin
        check($sformatf("v%0d output", k), if0.OUTPUT, v.out);
        check($sformatf("v%0d clip", k), if0.CLIP, v.clip);
      end
      if (c == 8) check($sformatf("v%0d output held", k), if0.OUTPUT, v.out);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{36'hFFF_FFF_FFF, 24'hFF_FF_FF, 3'b000, 3'b000, 4'd15, 0, 0, 0, 0, 11469, 1'b0};
    vecs[1] = '{36'h800_800_FFF, 24'hFF_FF_FF, 3'b001, 3'b000, 4'd15, 0, 0, 0, 4078, 0, 1'b0};
    vecs[2] = '{36'hFFF_FFF_FFF, 24'hFF_FF_FF, 3'b000, 3'b001, 4'd15, 32767, 0, 0, 0, 30719, 1'b1};
    vecs[3] = '{36'h000_000_000, 24'hFF_FF_FF, 3'b000, 3'b000, 4'd15, 0, 0, 0, 0, -11475, 1'b0};
    vecs[4] = '{36'hFFF_FFF_FFF, 24'hFF_FF_FF, 3'b000, 3'b000, 4'd0, 0, 0, 0, 0, 0, 1'b0};
    vecs[5] = '{36'hFFF_FFF_FFF, 24'hFF_FF_FF, 3'b111, 3'b010, 4'd15, 30000, 1000, -30000, 12234, 937, 1'b0};
    vecs[6] = '{36'h000_000_000, 24'hFF_FF_FF, 3'b000, 3'b110, 4'd15, 12345, -20000, -10000, 0, -30720, 1'b1};
    vecs[7] = '{36'h800_000_FFF, 24'hFF_FF_FF, 3'b011, 3'b111, 4'd8, 100, -50, 7, -2, 28, 1'b0};
    vecs[8] = '{36'h7FF_400_C00, 24'hFF_80_80, 3'b000, 3'b000, 4'd15, 0, 0, 0, 0, -2, 1'b0};
    vecs[9] = '{36'hFFF_FFF_FFF, 24'h00_00_FF, 3'b000, 3'b000, 4'd15, 0, 0, 0, 0, 3823, 1'b0};

    if0.START = 1'b0; if0.VOICES = '0; if0.ENVS = '0; if0.FILT = '0; if0.MODE = '0;
    if0.VOLUME = '0; if0.FILT_LP = '0; if0.FILT_BP = '0; if0.FILT_HP = '0;
    if8.START = 1'b0; if8.VOICES = '0; if8.ENVS = '0; if8.FILT = '0; if8.MODE = '0;
    if8.VOLUME = '0; if8.FILT_LP = '0; if8.FILT_BP = '0; if8.FILT_HP = '0;

    RST = 1'b1;
    repeat (3) step();
    RST = 1'b0;
    check("rst pre_filter", if0.PRE_FILTER, 0);
    check("rst pre_valid", if0.PRE_VALID, 0);
    check("rst output", if0.OUTPUT, 0);
    check("rst out_valid", if0.OUT_VALID, 0);
    check("rst busy", if0.BUSY, 0);
    check("rst clip", if0.CLIP, 0);
    check("rst8 busy", if8.BUSY, 0);
    check("rst8 output", if8.OUTPUT, 0);

    for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

    // Reset in cycle 2 of a frame aborts it without strobes
    load_vec(vecs[2]);
    if0.START = 1'b1;
    step();
    if0.START = 1'b0;
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("abort pre_filter", if0.PRE_FILTER, 0);
    check("abort output", if0.OUTPUT, 0);
    check("abort busy", if0.BUSY, 0);
    check("abort clip", if0.CLIP, 0);
    for (int c = 3; c <= 10; c++) begin
      check($sformatf("abort pre_valid c%0d", c), if0.PRE_VALID, 0);
      check($sformatf("abort out_valid c%0d", c), if0.OUT_VALID, 0);
      step();
    end
    run_vec(vecs[0], 10);

    // START held high: one frame every N+F+2 = 6 cycles
    load_vec(vecs[0]);
    if0.START = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check($sformatf("held out_valid c%0d", c), if0.OUT_VALID, (c > 0 && c % 6 == 0));
      check($sformatf("held busy c%0d", c), if0.BUSY, (c % 6 != 0));
      if (c > 0 && c % 6 == 0) check($sformatf("held output c%0d", c), if0.OUTPUT, 11469);
      step();
    end
    if0.START = 1'b0;
    repeat (8) step();
    check("held drained busy", if0.BUSY, 0);

    // 8-voice instance, HEADROOM=2: filter path saturates
    if8.VOICES  = {8{12'hFFF}};
    if8.ENVS    = {8{8'hFF}};
    if8.FILT    = 8'hFF;
    if8.MODE    = 3'b001;
    if8.VOLUME  = 4'd15;
    if8.FILT_LP = -16'sd1000;
    if8.FILT_BP = 16'sd5000;
    if8.FILT_HP = 16'sd5000;
    if8.START   = 1'b1;
    step();
    if8.START = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      check($sformatf("n8 pre_valid c%0d", c), if8.PRE_VALID, (c == 9));
      check($sformatf("n8 out_valid c%0d", c), if8.OUT_VALID, (c == 11));
      check($sformatf("n8 busy c%0d", c), if8.BUSY, (c <= 10));
      if (c == 9) check("n8 pre_filter", if8.PRE_FILTER, 32767);
      if (c == 11) begin
        check("n8 output", if8.OUTPUT, -938);
        check("n8 clip", if8.CLIP, 0);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
